// File: rtl/fsk_iq_source.sv
// Continuous-phase FSK I/Q sample source: bit handshake, phase accumulator, quarter-wave sine LUT.
// Optional macro FSK_IQ_ZERO_IDLE_EN: drive i_out/q_out to zero when the source drops back to IDLE.
module fsk_iq_source #(
    parameter int PHASE_W = 16,
    parameter int FDEV    = 1024,
    parameter int SPS     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic        bit_data,
    input  logic        bit_valid,
    output logic        bit_ready,
    output logic [13:0] i_out,
    output logic [13:0] q_out,
    output logic        iq_valid,
    output logic        underrun
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [PHASE_W-1:0] INC      = PHASE_W'(FDEV);
    localparam logic [7:0]         LAST_CNT = 8'(SPS - 1);

    state_t               state;
    logic [PHASE_W-1:0]   phase;
    logic [7:0]           sym_cnt;
    logic                 sym_bit;

    logic [PHASE_W-1:0]   phase_new;
    logic [5:0]           sin_idx;
    logic [5:0]           cos_idx;
    logic                 last_sym;

    function automatic logic [12:0] lut(input logic [4:0] k);
        logic [12:0] v;
        case (k)
            5'd0:    v = 13'd0;
            5'd1:    v = 13'd803;
            5'd2:    v = 13'd1598;
            5'd3:    v = 13'd2378;
            5'd4:    v = 13'd3135;
            5'd5:    v = 13'd3861;
            5'd6:    v = 13'd4551;
            5'd7:    v = 13'd5196;
            5'd8:    v = 13'd5792;
            5'd9:    v = 13'd6332;
            5'd10:   v = 13'd6811;
            5'd11:   v = 13'd7224;
            5'd12:   v = 13'd7567;
            5'd13:   v = 13'd7838;
            5'd14:   v = 13'd8034;
            5'd15:   v = 13'd8152;
            5'd16:   v = 13'd8191;
            default: v = 13'd0;
        endcase
        return v;
    endfunction

    // Quadrant fold: odd quadrants mirror the index, the upper half-circle negates.
    function automatic logic [13:0] sin14(input logic [5:0] idx);
        logic [4:0]  k;
        logic [13:0] m;
        k = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
        m = {1'b0, lut(k)};
        return idx[5] ? (14'd0 - m) : m;
    endfunction

    assign phase_new = sym_bit ? (phase + INC) : (phase - INC);
    assign sin_idx   = phase_new[PHASE_W-1 -: 6];
    assign cos_idx   = sin_idx + 6'd16;
    assign last_sym  = (sym_cnt == LAST_CNT);
    assign bit_ready = (state == IDLE) || (sample_tick && last_sym);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            sym_cnt  <= '0;
            sym_bit  <= 1'b0;
            i_out    <= '0;
            q_out    <= '0;
            iq_valid <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (bit_valid) begin
                        sym_bit <= bit_data;
                        sym_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (sample_tick) begin
                        phase    <= phase_new;
                        i_out    <= sin14(cos_idx);
                        q_out    <= sin14(sin_idx);
                        iq_valid <= 1'b1;
                        if (!last_sym) begin
                            sym_cnt <= sym_cnt + 8'd1;
                        end else if (bit_valid) begin
                            // Phase carries straight through the symbol boundary.
                            sym_bit <= bit_data;
                            sym_cnt <= '0;
                        end else begin
                            state    <= IDLE;
                            underrun <= 1'b1;
`ifdef FSK_IQ_ZERO_IDLE_EN
                            i_out    <= '0;
                            q_out    <= '0;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_iq_source.sv
// Scoreboard bench for fsk_iq_source: ticks push expected samples, a monitor pops and compares.
module tb_fsk_iq_source;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        bit_data = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_ready;
    logic [13:0] i_out;
    logic [13:0] q_out;
    logic        iq_valid;
    logic        underrun;

    always #5 clk = ~clk;

    fsk_iq_source dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .bit_data(bit_data), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .i_out(i_out), .q_out(q_out), .iq_valid(iq_valid), .underrun(underrun)
    );

    typedef struct {
        logic [13:0] i;
        logic [13:0] q;
        logic        v;
        logic        u;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_phase = '0;
    logic [13:0] m_i = '0;
    logic [13:0] m_q = '0;
    logic        m_v = 1'b0;
    logic        tick_q;

    // Independent reference: full-circle sine rounded half away from zero.
    function automatic logic [13:0] ref_sin(input logic [5:0] idx);
        real r;
        int  n;
        r = 8191.0 * $sin(3.14159265358979 * real'(idx) / 32.0);
        n = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        return 14'(n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tick_q <= 1'b0;
        else        tick_q <= sample_tick;

    always @(negedge clk) begin
        exp_t e;
        if (tick_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_sample actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                chk("sb_i_out", 32'(i_out), 32'(e.i));
                chk("sb_q_out", 32'(q_out), 32'(e.q));
                chk("sb_iq_valid", 32'(iq_valid), 32'(e.v));
                chk("sb_underrun", 32'(underrun), 32'(e.u));
            end
        end
    end

    // dir: +1/-1 advances the model phase, 0 means the tick must be ignored.
    task automatic do_tick(input int dir, input logic exp_u, input logic exp_rdy);
        exp_t       e;
        logic [5:0] si;
        logic [5:0] ci;
        @(negedge clk);
        sample_tick = 1'b1;
        if (dir != 0) begin
            m_phase = m_phase + ((dir > 0) ? 16'h0400 : 16'hFC00);
            si  = m_phase[15:10];
            ci  = si + 6'd16;
            m_i = ref_sin(ci);
            m_q = ref_sin(si);
            m_v = 1'b1;
        end
`ifdef FSK_IQ_ZERO_IDLE_EN
        if (exp_u) begin
            m_i = '0;
            m_q = '0;
        end
`endif
        e = '{i: m_i, q: m_q, v: m_v, u: exp_u};
        exp_q.push_back(e);
        #1 chk("bit_ready_tick", 32'(bit_ready), 32'(exp_rdy));
        @(posedge clk);
        #1 sample_tick = 1'b0;
    endtask

    task automatic accept(input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_data  = b;
        #1 chk("bit_ready_idle", 32'(bit_ready), 32'd1);
        @(posedge clk);
        #1 bit_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_phase = '0; m_i = '0; m_q = '0; m_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_out(input string name, input logic [13:0] ei, input logic [13:0] eq);
        @(negedge clk);
        chk({name, "_i"}, 32'(i_out), 32'(ei));
        chk({name, "_q"}, 32'(q_out), 32'(eq));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_i_out", 32'(i_out), 32'd0);
        chk("rst_q_out", 32'(q_out), 32'd0);
        chk("rst_iq_valid", 32'(iq_valid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_bit_ready", 32'(bit_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Bit 1, one tick: first sample above zero phase.
        accept(1'b1);
        do_tick(1, 1'b0, 1'b0);
        chk_out("t1", 14'h1FD8, 14'h0323);
        chk("t1_iq_valid", 32'(iq_valid), 32'd1);
        do_reset();

        // Bit 0, one tick: phase wraps below zero.
        accept(1'b0);
        do_tick(-1, 1'b0, 1'b0);
        chk("t2_phase", 32'(dut.phase), 32'h0000FC00);
        chk_out("t2", 14'h1FD8, 14'h3CDD);
        do_reset();

        // Bit 1 for a full symbol with no follow-up bit -> underrun.
        accept(1'b1);
        for (int k = 1; k <= 8; k++) do_tick(1, k == 8, k == 8);
        chk("t3_phase", 32'(dut.phase), 32'h00002000);
        @(negedge clk);
`ifdef FSK_IQ_ZERO_IDLE_EN
        chk("t3_i_out", 32'(i_out), 32'd0);
        chk("t3_q_out", 32'(q_out), 32'd0);
`else
        chk("t3_i_out", 32'(i_out), 32'd5792);
        chk("t3_q_out", 32'(q_out), 32'd5792);
`endif
        @(negedge clk);
        chk("t3_underrun_clear", 32'(underrun), 32'd0);
        chk("t3_idle_ready", 32'(bit_ready), 32'd1);
        do_tick(0, 1'b0, 1'b1);
        do_tick(0, 1'b0, 1'b1);

        // Next burst continues from the retained phase.
        accept(1'b0);
        do_tick(-1, 1'b0, 1'b0);
        chk_out("t3b", 14'd6332, 14'd5196);
        do_reset();

        // Bits 1 then 0 back-to-back; a third bit keeps the stream fed.
        accept(1'b1);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_data  = 1'b0;
        for (int k = 1; k <= 8; k++) do_tick(1, 1'b0, k == 8);
        chk("t4_phase_mid", 32'(dut.phase), 32'h00002000);
        bit_data = 1'b1;
        for (int k = 9; k <= 16; k++) do_tick(-1, 1'b0, k == 16);
        bit_valid = 1'b0;
        chk("t4_phase_end", 32'(dut.phase), 32'h00000000);
        chk_out("t4", 14'd8191, 14'd0);
        do_reset();

        // Asynchronous reset in the middle of a symbol.
        accept(1'b1);
        for (int k = 1; k <= 3; k++) do_tick(1, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        m_phase = '0; m_i = '0; m_q = '0; m_v = 1'b0;
        #1;
        chk("t6_i_out", 32'(i_out), 32'd0);
        chk("t6_q_out", 32'(q_out), 32'd0);
        chk("t6_iq_valid", 32'(iq_valid), 32'd0);
        chk("t6_underrun", 32'(underrun), 32'd0);
        chk("t6_bit_ready", 32'(bit_ready), 32'd1);
        chk("t6_phase", 32'(dut.phase), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        accept(1'b1);
        do_tick(1, 1'b0, 1'b0);
        chk_out("t6b", 14'h1FD8, 14'h0323);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsk_iq_source.md
Name: fsk_iq_source

Overview:
- Upstream stage of the IQ serializer.
- Consumes a stream of FSK data bits over a valid/ready handshake.
- Generates continuous-phase FSK baseband samples from a phase accumulator and a quarter-wave sine LUT.
- Presents registered, frame-stable 14-bit I/Q words to the serializer. A new sample is produced only on a one-cycle sample_tick, issued once per serializer I/Q frame.

Parameters:
- PHASE_W, 16: phase accumulator width. The LUT index is phase[PHASE_W-1:PHASE_W-6].
- FDEV, 1024: per-sample phase increment magnitude, in accumulator LSBs, mod 2^PHASE_W.
- SPS, 8: samples per symbol, legal range 2..255.

Ports:
- clk, in, 1: sole clock; all state updates on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- sample_tick, in, 1: one-cycle strobe requesting the next sample.
- bit_data, in, 1: FSK symbol. 1 = +FDEV, 0 = -FDEV.
- bit_valid, in, 1: bit_data is valid.
- bit_ready, out, 1: a bit is accepted in any cycle where bit_valid and bit_ready are both 1.
- i_out, out, 14: I sample, two's complement. Serializer sends it MSB first.
- q_out, out, 14: Q sample, two's complement.
- iq_valid, out, 1: at least one sample has been produced since reset.
- underrun, out, 1: one-cycle pulse when a symbol ends with no next bit available.

Behaviour:
- Reset values: i_out=0, q_out=0, iq_valid=0, underrun=0, phase=0, sym_cnt=0, state=IDLE.
  - bit_ready is combinational, so it equals 1 during reset (state IDLE).
- LUT: 17 entries, L[k]=round(8191*sin(pi*k/32)) for k=0..16, rounding half away from zero.
  - Example entries: L[0]=0, L[1]=803, L[8]=5792, L[15]=8152, L[16]=8191.
- sin(idx), with idx 6 bits, q=idx[5:4], k=idx[3:0]:
  - q0: L[k]
  - q1: L[16-k]
  - q2: -L[k]
  - q3: -L[16-k]
- cos(idx) = sin((idx+16) mod 64).
- Output range is ±8191; there is no overflow and no saturation.
- State machine, states IDLE and RUN:
  - IDLE: bit_ready=1. On bit_valid: latch bit_data into the current symbol, sym_cnt<=0, go to RUN. Phase and outputs are unchanged. sample_tick is ignored in IDLE, including a tick in the same cycle as the accept.
  - RUN, sample_tick=1:
    - phase_new = phase ± FDEV (wraps mod 2^PHASE_W).
    - phase<=phase_new, i_out<=cos(idx(phase_new)), q_out<=sin(idx(phase_new)), iq_valid<=1.
    - Outputs are visible one cycle after the tick edge.
    - If sym_cnt != SPS-1: sym_cnt++.
    - If sym_cnt == SPS-1 (symbol boundary):
      - bit_valid=1: latch new bit, sym_cnt<=0, stay in RUN. Phase is continuous; there is no reset at the boundary.
      - bit_valid=0: go to IDLE, underrun<=1 for one cycle.
  - RUN, sample_tick=0: bit_ready=0 and nothing changes.
- bit_ready in RUN = sample_tick && (sym_cnt == SPS-1), combinational.
- Phase persists across IDLE, so the next burst continues from the last phase.
- i_out/q_out change only on ticks. The upstream issuer must place ticks at a serializer frame boundary (ISYNC), so words never change mid-frame.
- rst_n asserted mid-symbol: immediate return to reset values; the in-flight bit is discarded.

Optional Feature:
- Macro FSK_IQ_ZERO_IDLE_EN.
- Defined: on the RUN->IDLE transition (underrun cycle), i_out and q_out are registered to 0. They stay 0 in IDLE; iq_valid is unaffected; phase is retained.
- Undefined: i_out and q_out hold the last sample during IDLE.

Test Plan:
- Reset, then bit_valid=1, bit_data=1, one tick -> i_out=8152 (0x1FD8), q_out=803 (0x0323), iq_valid=1, one cycle after the tick.
- From reset, bit 0, one tick -> phase=0xFC00, i_out=8152, q_out=-803 (0x3CDD).
- Bit 1, 8 ticks -> after tick 8, phase=0x2000, i_out=q_out=5792. bit_ready pulses only in the tick-8 cycle.
- Bits 1 then 0 back-to-back, 16 ticks -> phase rises to 0x2000, then returns to 0x0000. i_out=8191, q_out=0. No underrun.
- Single bit 1, 8 ticks, bit_valid held low -> underrun high for exactly one cycle after tick 8, state IDLE, further ticks leave the outputs unchanged. With FSK_IQ_ZERO_IDLE_EN defined: i_out=q_out=0 from that cycle.
- rst_n pulsed low mid-symbol at tick 3 -> all outputs return to reset values asynchronously; the next accepted bit 1 plus one tick gives 8152/803 again.
